// File: rtl/cdb_arbiter.sv
// Complete-stage CDB arbiter: three 2-entry result FIFOs (ALU, MUL, LD) drained
// one result per cycle in round-robin order onto a registered CDB broadcast.
module cdb_arbiter #(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_regdest,
  input  logic [ROB_W-1:0]  alu_rob,
  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              mul_regdest,
  input  logic [ROB_W-1:0]  mul_rob,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_regdest,
  input  logic [ROB_W-1:0]  ld_rob,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_regdest,
  output logic [ROB_W-1:0]  cdb_rob
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned ENT_W = TAG_W + DATA_W + 1 + ROB_W;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_LD  = 2'd2
  } src_e;

  src_e              rr_ptr;
  src_e              rr_next;
  logic [NSRC-1:0]   in_valid;
  logic [NSRC-1:0]   rdy;
  logic [NSRC-1:0]   enq;
  logic [NSRC-1:0]   deq;
  logic [ENT_W-1:0]  in_ent [NSRC];
  logic [ENT_W-1:0]  mem    [NSRC][2];
  logic [NSRC-1:0]   wr_ptr;
  logic [NSRC-1:0]   rd_ptr;
  logic [1:0]        count  [NSRC];
  logic              any_win;
  logic [1:0]        win;
  logic [2:0]        cand;
  logic [ENT_W-1:0]  head;

  assign in_valid  = {ld_valid, mul_valid, alu_valid};
  assign in_ent[0] = {alu_tag, alu_data, alu_regdest, alu_rob};
  assign in_ent[1] = {mul_tag, mul_data, mul_regdest, mul_rob};
  assign in_ent[2] = {ld_tag, ld_data, ld_regdest, ld_rob};

  assign alu_ready = rdy[0];
  assign mul_ready = rdy[1];
  assign ld_ready  = rdy[2];

  // Ready depends on occupancy only, never on a same-cycle dequeue
  always_comb begin
    rdy = '0;
    enq = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      rdy[i] = (count[i] < 2'd2);
      enq[i] = in_valid[i] & rdy[i] & ~flush;
    end
  end

  // Round-robin pick: first non-empty FIFO at or after rr_ptr
  always_comb begin
    any_win = 1'b0;
    win     = 2'd0;
    cand    = 3'd0;
    deq     = '0;
    rr_next = rr_ptr;
    for (int unsigned k = 0; k < NSRC; k++) begin
      cand = 3'(rr_ptr) + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!any_win && (count[cand[1:0]] != 2'd0)) begin
        any_win = 1'b1;
        win     = cand[1:0];
      end
    end
    head = mem[win][rd_ptr[win]];
    if (any_win && !flush) begin
      deq[win] = 1'b1;
      case (win)
        2'd0:    rr_next = SRC_MUL;
        2'd1:    rr_next = SRC_LD;
        default: rr_next = SRC_ALU;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= SRC_ALU;
    else      rr_ptr <= rr_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < NSRC; i++) count[i] <= 2'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < NSRC; i++) count[i] <= 2'd0;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (enq[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (deq[i]) rd_ptr[i] <= ~rd_ptr[i];
        count[i] <= count[i] + 2'(enq[i]) - 2'(deq[i]);
      end
    end
  end

  // Entry storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= in_ent[i];
    end
  end

  // Idle and flush cycles keep the last tag/data/rob on the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_regdest <= 1'b0;
      cdb_rob     <= '0;
    end else if (flush || !any_win) begin
      cdb_valid   <= 1'b0;
      cdb_regdest <= 1'b0;
    end else begin
      cdb_valid <= 1'b1;
      {cdb_tag, cdb_data, cdb_regdest, cdb_rob} <= head;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  v;
  logic [5:0]  tg [3];
  logic [31:0] dt [3];
  logic [2:0]  rd;
  logic [3:0]  rb [3];
  logic        alu_ready, mul_ready, ld_ready;
  logic        cdb_valid, cdb_regdest;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_rob;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(v[0]), .alu_ready(alu_ready), .alu_tag(tg[0]), .alu_data(dt[0]),
    .alu_regdest(rd[0]), .alu_rob(rb[0]),
    .mul_valid(v[1]), .mul_ready(mul_ready), .mul_tag(tg[1]), .mul_data(dt[1]),
    .mul_regdest(rd[1]), .mul_rob(rb[1]),
    .ld_valid(v[2]), .ld_ready(ld_ready), .ld_tag(tg[2]), .ld_data(dt[2]),
    .ld_regdest(rd[2]), .ld_rob(rb[2]),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_regdest(cdb_regdest), .cdb_rob(cdb_rob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  rob;
  } ent_t;

  ent_t        mq [3][$];
  int          rr;
  int          last_win;
  logic [2:0]  acc;
  logic        exp_v, exp_rd;
  logic [5:0]  exp_tag;
  logic [31:0] exp_data;
  logic [3:0]  exp_rob;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [5:0]  got_mul [$];
  logic        seen_mul_busy;
  int          mtag;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    rr = 0; exp_v = 1'b0; exp_rd = 1'b0;
    exp_tag = '0; exp_data = '0; exp_rob = '0;
  endtask

  // One clock edge of the reference: pop the round-robin winner, then accept inputs
  task automatic model_edge();
    int   sz [3];
    int   w;
    int   s;
    ent_t e;
    for (int i = 0; i < 3; i++) sz[i] = mq[i].size();
    acc = '0;
    last_win = -1;
    if (flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      exp_v = 1'b0; exp_rd = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < 3; k++) begin
        s = (rr + k) % 3;
        if (w < 0 && sz[s] > 0) w = s;
      end
      if (w >= 0) begin
        e = mq[w].pop_front();
        exp_v = 1'b1; exp_tag = e.tag; exp_data = e.data; exp_rd = e.rd; exp_rob = e.rob;
        rr = (w + 1) % 3;
        last_win = w;
      end else begin
        exp_v = 1'b0; exp_rd = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && sz[i] < 2) begin
          e.tag = tg[i]; e.data = dt[i]; e.rd = rd[i]; e.rob = rb[i];
          mq[i].push_back(e);
          acc[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_rdy;
    for (int i = 0; i < 3; i++) exp_rdy[i] = (mq[i].size() < 2);
    chk("cdb_valid",   64'(cdb_valid),   64'(exp_v));
    chk("cdb_regdest", 64'(cdb_regdest), 64'(exp_rd));
    chk("cdb_tag",     64'(cdb_tag),     64'(exp_tag));
    chk("cdb_data",    64'(cdb_data),    64'(exp_data));
    chk("cdb_rob",     64'(cdb_rob),     64'(exp_rob));
    chk("readies",     64'({ld_ready, mul_ready, alu_ready}), 64'(exp_rdy));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_src(input int s, input logic val, input logic [5:0] t,
                         input logic [31:0] d, input logic r, input logic [3:0] ro);
    v[s] = val; tg[s] = t; dt[s] = d; rd[s] = r; rb[s] = ro;
  endtask

  task automatic rand_src(input int s);
    set_src(s, 1'($urandom_range(0, 1)), 6'($urandom), $urandom, 1'($urandom), 4'($urandom));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 6'd0, 32'd0, 1'b0, 4'd0);
    model_reset();
    #1;
    check_outputs();
    #20 rst = 1'b1;

    // Single ALU result
    set_src(0, 1'b1, 6'h05, 32'hDEADBEEF, 1'b1, 4'd3);
    step();
    chk("t1_no_early_valid", 64'(cdb_valid), 64'd0);
    v = '0;
    step();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag", 64'(cdb_tag), 64'h05);
    chk("t1_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("t1_rob", 64'(cdb_rob), 64'd3);
    step();
    chk("t1_valid_drop", 64'(cdb_valid), 64'd0);

    // LD with regdest=0 and tag 0; leaves the pointer at ALU
    set_src(2, 1'b1, 6'h00, 32'h1234_5678, 1'b0, 4'd9);
    step();
    v = '0;
    step();
    chk("t4_valid", 64'(cdb_valid), 64'd1);
    chk("t4_regdest", 64'(cdb_regdest), 64'd0);
    chk("t4_tag", 64'(cdb_tag), 64'h00);
    chk("t4_rob", 64'(cdb_rob), 64'd9);
    step();

    // All three sources at once
    set_src(0, 1'b1, 6'h11, 32'hA0A0_0001, 1'b1, 4'd1);
    set_src(1, 1'b1, 6'h22, 32'hB0B0_0002, 1'b1, 4'd2);
    set_src(2, 1'b1, 6'h33, 32'hC0C0_0003, 1'b1, 4'd4);
    step();
    v = '0;
    step(); chk("t2_first_alu", 64'(cdb_tag), 64'h11);
    step(); chk("t2_second_mul", 64'(cdb_tag), 64'h22);
    step(); chk("t2_third_ld", 64'(cdb_tag), 64'h33);
    step(); chk("t2_idle", 64'(cdb_valid), 64'd0);

    // MUL tags 1..4 under continuous ALU/LD pressure
    mtag = 1;
    seen_mul_busy = 1'b0;
    set_src(0, 1'b1, 6'h20, $urandom, 1'b1, 4'd0);
    set_src(1, 1'b1, 6'd1, 32'h0000_0101, 1'b1, 4'd5);
    set_src(2, 1'b1, 6'h30, $urandom, 1'b1, 4'd0);
    for (int c = 0; c < 60 && got_mul.size() < 4; c++) begin
      step();
      if (!mul_ready) seen_mul_busy = 1'b1;
      if (cdb_valid && last_win == 1) got_mul.push_back(cdb_tag);
      if (acc[0]) set_src(0, 1'b1, 6'($urandom_range(32, 47)), $urandom, 1'b1, 4'($urandom));
      if (acc[2]) set_src(2, 1'b1, 6'($urandom_range(48, 63)), $urandom, 1'b1, 4'($urandom));
      if (acc[1]) begin
        if (mtag == 4) v[1] = 1'b0;
        else begin
          mtag++;
          set_src(1, 1'b1, 6'(mtag), 32'h0000_0100 + 32'(mtag), 1'b1, 4'd5);
        end
      end
    end
    chk("t3_mul_ready_dropped", 64'(seen_mul_busy), 64'd1);
    chk("t3_mul_count", 64'(got_mul.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_mul.size()) chk("t3_mul_order", 64'(got_mul[i]), 64'(i + 1));
    end
    v = '0;
    for (int i = 0; i < 8; i++) step();

    // Flush with several FIFOs occupied and inputs presented
    set_src(0, 1'b1, 6'h01, 32'h1, 1'b1, 4'd1);
    set_src(1, 1'b1, 6'h02, 32'h2, 1'b1, 4'd2);
    set_src(2, 1'b1, 6'h03, 32'h3, 1'b1, 4'd3);
    step();
    v[1] = 1'b0;
    tg[0] = 6'h04; tg[2] = 6'h06;
    step();
    v = 3'b111; flush = 1'b1;
    step();
    chk("t5_flush_valid", 64'(cdb_valid), 64'd0);
    chk("t5_flush_ready", 64'({ld_ready, mul_ready, alu_ready}), 64'h7);
    flush = 1'b0; v = '0;
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset while broadcasting with FIFOs non-empty
    set_src(0, 1'b1, 6'h0A, 32'hAAAA_0000, 1'b1, 4'd7);
    set_src(1, 1'b1, 6'h0B, 32'hBBBB_0000, 1'b1, 4'd8);
    set_src(2, 1'b1, 6'h0C, 32'hCCCC_0000, 1'b1, 4'd9);
    step();
    v = '0;
    step();
    chk("t6_busy_before_rst", 64'(cdb_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", 64'(cdb_valid), 64'd0);
    chk("t6_rst_bus", 64'({cdb_tag, cdb_data, cdb_regdest, cdb_rob}), 64'd0);
    check_outputs();
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic with held results and occasional flushes
    for (int s = 0; s < 3; s++) rand_src(s);
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 29) == 0);
      step();
      for (int s = 0; s < 3; s++) begin
        if (!(v[s] && !acc[s])) rand_src(s);
      end
    end
    flush = 1'b0; v = '0;
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
